// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: operand selects, forward selects
// and the field values that make up a pipeline bubble.
package ex_pkg;

  localparam logic [1:0] OPA_RS1  = 2'b00;
  localparam logic [1:0] OPA_PC   = 2'b01;
  localparam logic [1:0] OPA_ZERO = 2'b10;

  localparam logic OPB_RS2 = 1'b0;
  localparam logic OPB_IMM = 1'b1;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  localparam logic [4:0] BUBBLE_RD      = 5'd0;
  localparam logic [4:0] BUBBLE_OPCODE  = 5'd0;
  localparam logic [1:0] BUBBLE_OPA_SEL = OPA_RS1;
  localparam logic       BUBBLE_OPB_SEL = OPB_RS2;

endpackage

// File: rtl/forward_mux.sv
// Selects one source operand from the EX/MEM result, the MEM/WB result or the
// registered read data. x0 is never forwarded and the younger EX/MEM producer wins.
module forward_mux
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      i_addr,
  input  logic [XLEN-1:0] i_reg_data,
  input  logic [4:0]      i_exmem_rd,
  input  logic            i_exmem_wb_en,
  input  logic [XLEN-1:0] i_exmem_data,
  input  logic [4:0]      i_memwb_rd,
  input  logic            i_memwb_wb_en,
  input  logic [XLEN-1:0] i_memwb_data,
  output logic [XLEN-1:0] o_data,
  output fwd_sel_e        o_sel
);

  always_comb begin
    o_sel  = FWD_NONE;
    o_data = i_reg_data;
    if (i_addr == 5'd0) begin
      o_sel  = FWD_NONE;
      o_data = i_reg_data;
    end else if (i_exmem_wb_en && (i_exmem_rd == i_addr)) begin
      o_sel  = FWD_EXMEM;
      o_data = i_exmem_data;
    end else if (i_memwb_wb_en && (i_memwb_rd == i_addr)) begin
      o_sel  = FWD_MEMWB;
      o_data = i_memwb_data;
    end else begin
      o_sel  = FWD_NONE;
      o_data = i_reg_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush, plus execute-stage forwarding,
// ALU operand selection, store data and branch/jump target generation.
module id_ex_stage
  import ex_pkg::*;
#(
  parameter int              XLEN   = 32,
  parameter logic [XLEN-1:0] RST_PC = 32'h0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            id_valid_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [XLEN-1:0] id_rs1_data_i,
  input  logic [XLEN-1:0] id_rs2_data_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [4:0]      id_rs1_addr_i,
  input  logic [4:0]      id_rs2_addr_i,
  input  logic [4:0]      id_rd_addr_i,
  input  logic [4:0]      id_alu_opcode_i,
  input  logic [1:0]      id_op_a_sel_i,
  input  logic            id_op_b_sel_i,
  input  logic            id_wb_en_i,
  input  logic            id_mem_we_i,
  input  logic            id_mem_re_i,
  input  logic            id_is_branch_i,
  input  logic            id_is_jal_i,
  input  logic            id_is_jalr_i,
  input  logic [4:0]      exmem_rd_i,
  input  logic            exmem_wb_en_i,
  input  logic [XLEN-1:0] exmem_data_i,
  input  logic [4:0]      memwb_rd_i,
  input  logic            memwb_wb_en_i,
  input  logic [XLEN-1:0] memwb_data_i,
  output logic [4:0]      alu_opcode_o,
  output logic [XLEN-1:0] alu_op_a_o,
  output logic [XLEN-1:0] alu_op_b_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [XLEN-1:0] branch_target_o,
  output logic [XLEN-1:0] link_data_o,
  output logic            ex_valid_o,
  output logic [4:0]      ex_rd_addr_o,
  output logic            ex_wb_en_o,
  output logic            ex_mem_we_o,
  output logic            ex_mem_re_o,
  output logic            ex_is_branch_o,
  output logic            ex_is_jump_o
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

  logic            r_valid, r_op_b_sel, r_wb_en, r_mem_we, r_mem_re;
  logic            r_is_branch, r_is_jal, r_is_jalr;
  logic [XLEN-1:0] r_pc, r_rs1_data, r_rs2_data, r_imm;
  logic [4:0]      r_rs1_addr, r_rs2_addr, r_rd, r_alu_opcode;
  logic [1:0]      r_op_a_sel;

  logic [XLEN-1:0] w_fwd_rs1, w_fwd_rs2, w_op_a, w_jalr_sum;
  fwd_sel_e        w_rs1_sel_unused, w_rs2_sel_unused;

  // Reset and flush both produce a bubble; stall simply withholds the load.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || flush_i) begin
      r_valid      <= 1'b0;
      r_pc         <= RST_PC;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_imm        <= '0;
      r_rs1_addr   <= 5'd0;
      r_rs2_addr   <= 5'd0;
      r_rd         <= BUBBLE_RD;
      r_alu_opcode <= BUBBLE_OPCODE;
      r_op_a_sel   <= BUBBLE_OPA_SEL;
      r_op_b_sel   <= BUBBLE_OPB_SEL;
      r_wb_en      <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_re     <= 1'b0;
      r_is_branch  <= 1'b0;
      r_is_jal     <= 1'b0;
      r_is_jalr    <= 1'b0;
    end else if (!stall_i) begin
      r_valid      <= id_valid_i;
      r_pc         <= id_pc_i;
      r_rs1_data   <= id_rs1_data_i;
      r_rs2_data   <= id_rs2_data_i;
      r_imm        <= id_imm_i;
      r_rs1_addr   <= id_rs1_addr_i;
      r_rs2_addr   <= id_rs2_addr_i;
      r_rd         <= id_rd_addr_i;
      r_alu_opcode <= id_alu_opcode_i;
      r_op_a_sel   <= id_op_a_sel_i;
      r_op_b_sel   <= id_op_b_sel_i;
      r_wb_en      <= id_wb_en_i;
      r_mem_we     <= id_mem_we_i;
      r_mem_re     <= id_mem_re_i;
      r_is_branch  <= id_is_branch_i;
      r_is_jal     <= id_is_jal_i;
      r_is_jalr    <= id_is_jalr_i;
    end
  end

  forward_mux #(.XLEN(XLEN)) u_fwd_rs1 (
    .i_addr        (r_rs1_addr),
    .i_reg_data    (r_rs1_data),
    .i_exmem_rd    (exmem_rd_i),
    .i_exmem_wb_en (exmem_wb_en_i),
    .i_exmem_data  (exmem_data_i),
    .i_memwb_rd    (memwb_rd_i),
    .i_memwb_wb_en (memwb_wb_en_i),
    .i_memwb_data  (memwb_data_i),
    .o_data        (w_fwd_rs1),
    .o_sel         (w_rs1_sel_unused)
  );

  forward_mux #(.XLEN(XLEN)) u_fwd_rs2 (
    .i_addr        (r_rs2_addr),
    .i_reg_data    (r_rs2_data),
    .i_exmem_rd    (exmem_rd_i),
    .i_exmem_wb_en (exmem_wb_en_i),
    .i_exmem_data  (exmem_data_i),
    .i_memwb_rd    (memwb_rd_i),
    .i_memwb_wb_en (memwb_wb_en_i),
    .i_memwb_data  (memwb_data_i),
    .o_data        (w_fwd_rs2),
    .o_sel         (w_rs2_sel_unused)
  );

  // The reserved select encoding falls into the zero operand.
  always_comb begin
    w_op_a = '0;
    case (r_op_a_sel)
      OPA_RS1: w_op_a = w_fwd_rs1;
      OPA_PC:  w_op_a = r_pc;
      default: w_op_a = '0;
    endcase
  end

  assign w_jalr_sum      = w_fwd_rs1 + r_imm;
  assign alu_opcode_o    = r_alu_opcode;
  assign alu_op_a_o      = w_op_a;
  assign alu_op_b_o      = (r_op_b_sel == OPB_IMM) ? r_imm : w_fwd_rs2;
  assign store_data_o    = w_fwd_rs2;
  assign branch_target_o = r_is_jalr ? {w_jalr_sum[XLEN-1:1], 1'b0} : (r_pc + r_imm);
  assign link_data_o     = r_pc + PC_STEP;

  assign ex_valid_o     = r_valid;
  assign ex_rd_addr_o   = r_rd;
  assign ex_wb_en_o     = r_valid & r_wb_en;
  assign ex_mem_we_o    = r_valid & r_mem_we;
  assign ex_mem_re_o    = r_valid & r_mem_re;
  assign ex_is_branch_o = r_valid & r_is_branch;
  assign ex_is_jump_o   = r_valid & (r_is_jal | r_is_jalr);

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic compared against an instruction-level model of the EX slot.
module tb_id_ex_stage;

  localparam int          XLEN    = 32;
  localparam logic [31:0] RST_PC  = 32'h0;
  localparam logic [4:0]  OPC_ADD = 5'h01;
  localparam logic [4:0]  OPC_LUI = 5'h10;

  logic        clk_i = 1'b0;
  logic        rst_i, stall_i, flush_i, id_valid_i;
  logic [31:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_alu_opcode_i;
  logic [1:0]  id_op_a_sel_i;
  logic        id_op_b_sel_i, id_wb_en_i, id_mem_we_i, id_mem_re_i;
  logic        id_is_branch_i, id_is_jal_i, id_is_jalr_i;
  logic [4:0]  exmem_rd_i, memwb_rd_i;
  logic        exmem_wb_en_i, memwb_wb_en_i;
  logic [31:0] exmem_data_i, memwb_data_i;
  logic [4:0]  alu_opcode_o, ex_rd_addr_o;
  logic [31:0] alu_op_a_o, alu_op_b_o, store_data_o, branch_target_o, link_data_o;
  logic        ex_valid_o, ex_wb_en_o, ex_mem_we_o, ex_mem_re_o, ex_is_branch_o, ex_is_jump_o;

  int n_checks = 0;
  int n_fail   = 0;

  id_ex_stage #(.XLEN(XLEN), .RST_PC(RST_PC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_pc_i(id_pc_i), .id_rs1_data_i(id_rs1_data_i),
    .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i), .id_rs1_addr_i(id_rs1_addr_i),
    .id_rs2_addr_i(id_rs2_addr_i), .id_rd_addr_i(id_rd_addr_i),
    .id_alu_opcode_i(id_alu_opcode_i), .id_op_a_sel_i(id_op_a_sel_i),
    .id_op_b_sel_i(id_op_b_sel_i), .id_wb_en_i(id_wb_en_i), .id_mem_we_i(id_mem_we_i),
    .id_mem_re_i(id_mem_re_i), .id_is_branch_i(id_is_branch_i), .id_is_jal_i(id_is_jal_i),
    .id_is_jalr_i(id_is_jalr_i), .exmem_rd_i(exmem_rd_i), .exmem_wb_en_i(exmem_wb_en_i),
    .exmem_data_i(exmem_data_i), .memwb_rd_i(memwb_rd_i), .memwb_wb_en_i(memwb_wb_en_i),
    .memwb_data_i(memwb_data_i), .alu_opcode_o(alu_opcode_o), .alu_op_a_o(alu_op_a_o),
    .alu_op_b_o(alu_op_b_o), .store_data_o(store_data_o), .branch_target_o(branch_target_o),
    .link_data_o(link_data_o), .ex_valid_o(ex_valid_o), .ex_rd_addr_o(ex_rd_addr_o),
    .ex_wb_en_o(ex_wb_en_o), .ex_mem_we_o(ex_mem_we_o), .ex_mem_re_o(ex_mem_re_o),
    .ex_is_branch_o(ex_is_branch_o), .ex_is_jump_o(ex_is_jump_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1a, rs2a, rd, opc;
    logic [1:0]  asel;
    logic        bsel, wb, mwe, mre, br, jal, jalr;
  } instr_t;

  instr_t m;  // instruction the model believes sits in the EX slot

  function automatic instr_t bubble_instr();
    instr_t r = '0;
    r.pc = RST_PC;
    return r;
  endfunction

  function automatic instr_t nop_instr();
    instr_t r = '0;
    r.valid = 1'b1;
    return r;
  endfunction

  function automatic instr_t rand_instr();
    instr_t      r;
    logic [31:0] v = $urandom;
    r.valid = v[0];   r.bsel = v[1];  r.wb = v[2];   r.mwe = v[3];
    r.mre = v[4];     r.br = v[5];    r.jal = v[6];  r.jalr = v[7];
    r.asel = v[9:8];
    r.rs1a = {3'b000, v[11:10]};
    r.rs2a = {3'b000, v[13:12]};
    r.rd = v[18:14];  r.opc = v[23:19];
    r.pc = $urandom;  r.rs1d = $urandom;  r.rs2d = $urandom;  r.imm = $urandom;
    return r;
  endfunction

  function automatic instr_t cur_id();
    instr_t r;
    r.valid = id_valid_i;  r.pc = id_pc_i;  r.rs1d = id_rs1_data_i;
    r.rs2d = id_rs2_data_i;  r.imm = id_imm_i;  r.rs1a = id_rs1_addr_i;
    r.rs2a = id_rs2_addr_i;  r.rd = id_rd_addr_i;  r.opc = id_alu_opcode_i;
    r.asel = id_op_a_sel_i;  r.bsel = id_op_b_sel_i;  r.wb = id_wb_en_i;
    r.mwe = id_mem_we_i;  r.mre = id_mem_re_i;  r.br = id_is_branch_i;
    r.jal = id_is_jal_i;  r.jalr = id_is_jalr_i;
    return r;
  endfunction

  task automatic drive(input instr_t x);
    id_valid_i = x.valid;  id_pc_i = x.pc;  id_rs1_data_i = x.rs1d;
    id_rs2_data_i = x.rs2d;  id_imm_i = x.imm;  id_rs1_addr_i = x.rs1a;
    id_rs2_addr_i = x.rs2a;  id_rd_addr_i = x.rd;  id_alu_opcode_i = x.opc;
    id_op_a_sel_i = x.asel;  id_op_b_sel_i = x.bsel;  id_wb_en_i = x.wb;
    id_mem_we_i = x.mwe;  id_mem_re_i = x.mre;  id_is_branch_i = x.br;
    id_is_jal_i = x.jal;  id_is_jalr_i = x.jalr;
  endtask

  task automatic clr_fwd();
    exmem_rd_i = 5'd0;  exmem_wb_en_i = 1'b0;  exmem_data_i = 32'h0;
    memwb_rd_i = 5'd0;  memwb_wb_en_i = 1'b0;  memwb_data_i = 32'h0;
  endtask

  // One rising edge; the model applies reset > flush > stall > load.
  task automatic tick();
    @(posedge clk_i);
    if (rst_i || flush_i) m = bubble_instr();
    else if (!stall_i)    m = cur_id();
    #1;
  endtask

  // Reference forwarding rule for one source register.
  function automatic logic [31:0] exp_fwd(input logic [4:0] a, input logic [31:0] d);
    if (a == 5'd0) return d;
    if (exmem_wb_en_i && exmem_rd_i == a) return exmem_data_i;
    if (memwb_wb_en_i && memwb_rd_i == a) return memwb_data_i;
    return d;
  endfunction

  function automatic logic [31:0] exp_op_a();
    if (m.asel == 2'b00) return exp_fwd(m.rs1a, m.rs1d);
    if (m.asel == 2'b01) return m.pc;
    return 32'h0;
  endfunction

  function automatic logic [31:0] exp_target();
    if (m.jalr) return (exp_fwd(m.rs1a, m.rs1d) + m.imm) & 32'hFFFF_FFFE;
    return m.pc + m.imm;
  endfunction

  task automatic test_reset();
    instr_t x = nop_instr();
    x.wb = 1'b1;  x.rd = 5'd9;
    rst_i = 1'b1;  stall_i = 1'b0;  flush_i = 1'b0;
    drive(x);  clr_fwd();
    #1;
    n_checks++;
    if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_async_valid got %0b want 0", ex_valid_o); end
    repeat (2) tick();
    n_checks++;
    if (ex_valid_o !== 1'b0 || ex_wb_en_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl valid=%0b wb=%0b want 0/0", ex_valid_o, ex_wb_en_o);
    end
    n_checks++;
    if (link_data_o !== RST_PC + 32'd4) begin n_fail++; $display("FAIL reset_link got %h want %h", link_data_o, RST_PC + 32'd4); end
    n_checks++;
    if (branch_target_o !== RST_PC || alu_opcode_o !== 5'd0) begin
      n_fail++; $display("FAIL reset_target_opc got %h/%h want %h/0", branch_target_o, alu_opcode_o, RST_PC);
    end
  endtask

  task automatic test_load_add();
    instr_t x = nop_instr();
    x.rs1a = 5'd1;  x.rs1d = 32'd5;  x.rs2a = 5'd2;  x.rs2d = 32'd7;
    x.rd = 5'd3;  x.opc = OPC_ADD;  x.wb = 1'b1;
    rst_i = 1'b0;
    drive(x);
    tick();
    n_checks++;
    if (alu_op_a_o !== 32'd5 || alu_op_b_o !== 32'd7) begin
      n_fail++; $display("FAIL add_operands got %0d/%0d want 5/7", alu_op_a_o, alu_op_b_o);
    end
    n_checks++;
    if (alu_opcode_o !== OPC_ADD || ex_rd_addr_o !== 5'd3 || ex_wb_en_o !== 1'b1 || ex_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL add_ctrl opc=%h rd=%0d wb=%0b v=%0b want %h/3/1/1",
                         alu_opcode_o, ex_rd_addr_o, ex_wb_en_o, ex_valid_o, OPC_ADD);
    end
  endtask

  task automatic test_dual_forward();
    instr_t x = nop_instr();
    x.rs1a = 5'd1;  x.rs1d = 32'd5;  x.rs2a = 5'd2;  x.rs2d = 32'd7;
    drive(x);  clr_fwd();
    tick();
    exmem_rd_i = 5'd1;  exmem_wb_en_i = 1'b1;  exmem_data_i = 32'd100;
    memwb_rd_i = 5'd1;  memwb_wb_en_i = 1'b1;  memwb_data_i = 32'd200;
    #1;
    n_checks++;
    if (alu_op_a_o !== 32'd100) begin n_fail++; $display("FAIL fwd_both got %0d want 100", alu_op_a_o); end
    exmem_wb_en_i = 1'b0;
    #1;
    n_checks++;
    if (alu_op_a_o !== 32'd200) begin n_fail++; $display("FAIL fwd_memwb got %0d want 200", alu_op_a_o); end
    memwb_wb_en_i = 1'b0;
    #1;
    n_checks++;
    if (alu_op_a_o !== 32'd5) begin n_fail++; $display("FAIL fwd_none got %0d want 5", alu_op_a_o); end
    memwb_rd_i = 5'd2;  memwb_wb_en_i = 1'b1;  memwb_data_i = 32'h77;
    #1;
    n_checks++;
    if (store_data_o !== 32'h77 || alu_op_b_o !== 32'h77) begin
      n_fail++; $display("FAIL fwd_rs2 store=%h opb=%h want 77/77", store_data_o, alu_op_b_o);
    end
    clr_fwd();
  endtask

  task automatic test_x0_guard();
    instr_t x = nop_instr();
    drive(x);
    tick();
    exmem_rd_i = 5'd0;  exmem_wb_en_i = 1'b1;  exmem_data_i = 32'hDEAD;
    memwb_rd_i = 5'd0;  memwb_wb_en_i = 1'b1;  memwb_data_i = 32'hBEEF;
    #1;
    n_checks++;
    if (alu_op_a_o !== 32'h0 || store_data_o !== 32'h0) begin
      n_fail++; $display("FAIL x0_guard opa=%h store=%h want 0/0", alu_op_a_o, store_data_o);
    end
    clr_fwd();
  endtask

  task automatic test_stall_flush();
    instr_t a = nop_instr();
    a.rs1a = 5'd1;  a.rs1d = 32'hA1;  a.imm = 32'h44;  a.bsel = 1'b1;
    a.opc = 5'h02;  a.mwe = 1'b1;
    drive(a);
    tick();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr_t y = rand_instr();
      y.valid = 1'b1;
      drive(y);
      tick();
      n_checks++;
      if (alu_op_a_o !== 32'hA1 || alu_op_b_o !== 32'h44 || alu_opcode_o !== 5'h02 || ex_mem_we_o !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold cyc%0d opa=%h opb=%h opc=%h we=%0b want a1/44/02/1",
                           i, alu_op_a_o, alu_op_b_o, alu_opcode_o, ex_mem_we_o);
      end
    end
    flush_i = 1'b1;
    tick();
    n_checks++;
    if (ex_valid_o !== 1'b0 || ex_mem_we_o !== 1'b0 || alu_opcode_o !== 5'd0 || link_data_o !== RST_PC + 32'd4) begin
      n_fail++; $display("FAIL stall_flush_bubble v=%0b we=%0b opc=%h link=%h want 0/0/0/%h",
                         ex_valid_o, ex_mem_we_o, alu_opcode_o, link_data_o, RST_PC + 32'd4);
    end
    stall_i = 1'b0;  flush_i = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    instr_t x = nop_instr();
    x.rs1a = 5'd3;  x.rs1d = 32'h1234;
    drive(x);
    tick();
    stall_i = 1'b1;
    #2;
    rst_i = 1'b1;
    m = bubble_instr();
    #1;
    n_checks++;
    if (ex_valid_o !== 1'b0 || alu_op_a_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_stall v=%0b opa=%h want 0/0", ex_valid_o, alu_op_a_o);
    end
    tick();
    rst_i = 1'b0;  stall_i = 1'b0;
    x.rs1d = 32'h5678;
    drive(x);
    tick();
    n_checks++;
    if (ex_valid_o !== 1'b1 || alu_op_a_o !== 32'h5678) begin
      n_fail++; $display("FAIL reset_release_load v=%0b opa=%h want 1/5678", ex_valid_o, alu_op_a_o);
    end
  endtask

  task automatic test_operand_select();
    instr_t x = nop_instr();
    x.imm = 32'h12345000;  x.bsel = 1'b1;  x.opc = OPC_LUI;  x.asel = 2'b10;
    x.rs1a = 5'd4;  x.rs1d = 32'h99;
    drive(x);
    tick();
    n_checks++;
    if (alu_op_b_o !== 32'h12345000 || alu_op_a_o !== 32'h0 || alu_opcode_o !== OPC_LUI) begin
      n_fail++; $display("FAIL lui opb=%h opa=%h opc=%h want 12345000/0/%h", alu_op_b_o, alu_op_a_o, alu_opcode_o, OPC_LUI);
    end
    x.pc = 32'h100;  x.asel = 2'b01;  x.imm = 32'h2000;
    drive(x);
    tick();
    n_checks++;
    if (alu_op_a_o !== 32'h100 || alu_op_b_o !== 32'h2000) begin
      n_fail++; $display("FAIL auipc opa=%h opb=%h want 100/2000", alu_op_a_o, alu_op_b_o);
    end
    x.asel = 2'b11;
    drive(x);
    tick();
    n_checks++;
    if (alu_op_a_o !== 32'h0) begin n_fail++; $display("FAIL opa_reserved got %h want 0", alu_op_a_o); end
  endtask

  task automatic test_jump_targets();
    instr_t x = nop_instr();
    x.rs1a = 5'd5;  x.imm = 32'd4;  x.jalr = 1'b1;  x.pc = 32'h40;
    drive(x);
    tick();
    exmem_rd_i = 5'd5;  exmem_wb_en_i = 1'b1;  exmem_data_i = 32'h203;
    #1;
    n_checks++;
    if (branch_target_o !== 32'h206 || ex_is_jump_o !== 1'b1) begin
      n_fail++; $display("FAIL jalr_target got %h jump=%0b want 206/1", branch_target_o, ex_is_jump_o);
    end
    clr_fwd();
    x = nop_instr();
    x.pc = 32'hFFFF_FFFC;  x.imm = 32'd8;  x.jal = 1'b1;
    drive(x);
    tick();
    n_checks++;
    if (link_data_o !== 32'h0 || branch_target_o !== 32'h4) begin
      n_fail++; $display("FAIL jal_wrap link=%h target=%h want 0/4", link_data_o, branch_target_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [10:0] exp_ctrl;
    for (int i = 0; i < 400; i++) begin
      v = $urandom;
      drive(rand_instr());
      stall_i = (v[1:0] == 2'b00);
      flush_i = (v[4:2] == 3'b000);
      rst_i   = (v[9:5] == 5'b00000);
      tick();
      rst_i = 1'b0;
      v = $urandom;
      exmem_rd_i = {3'b000, v[1:0]};  exmem_wb_en_i = v[2];  exmem_data_i = $urandom;
      memwb_rd_i = {3'b000, v[4:3]};  memwb_wb_en_i = v[5];  memwb_data_i = $urandom;
      #1;
      exp_ctrl = {m.valid, m.rd, m.valid & m.wb, m.valid & m.mwe, m.valid & m.mre,
                  m.valid & m.br, m.valid & (m.jal | m.jalr)};
      n_checks++;
      if ({ex_valid_o, ex_rd_addr_o, ex_wb_en_o, ex_mem_we_o, ex_mem_re_o, ex_is_branch_o, ex_is_jump_o} !== exp_ctrl) begin
        n_fail++; $display("FAIL rand_ctrl it%0d got %h want %h", i,
          {ex_valid_o, ex_rd_addr_o, ex_wb_en_o, ex_mem_we_o, ex_mem_re_o, ex_is_branch_o, ex_is_jump_o}, exp_ctrl);
      end
      n_checks++;
      if (alu_op_a_o !== exp_op_a() || alu_opcode_o !== m.opc) begin
        n_fail++; $display("FAIL rand_opa it%0d got %h/%h want %h/%h", i, alu_op_a_o, alu_opcode_o, exp_op_a(), m.opc);
      end
      n_checks++;
      if (alu_op_b_o !== (m.bsel ? m.imm : exp_fwd(m.rs2a, m.rs2d)) || store_data_o !== exp_fwd(m.rs2a, m.rs2d)) begin
        n_fail++; $display("FAIL rand_opb it%0d got %h/%h want %h/%h", i, alu_op_b_o, store_data_o,
                           m.bsel ? m.imm : exp_fwd(m.rs2a, m.rs2d), exp_fwd(m.rs2a, m.rs2d));
      end
      n_checks++;
      if (link_data_o !== m.pc + 32'd4) begin
        n_fail++; $display("FAIL rand_link it%0d got %h want %h", i, link_data_o, m.pc + 32'd4);
      end
      if (m.valid) begin
        n_checks++;
        if (branch_target_o !== exp_target()) begin
          n_fail++; $display("FAIL rand_target it%0d got %h want %h", i, branch_target_o, exp_target());
        end
      end
    end
    stall_i = 1'b0;  flush_i = 1'b0;  clr_fwd();
  endtask

  initial begin
    m = bubble_instr();
    test_reset();
    test_load_add();
    test_dual_forward();
    test_x0_guard();
    test_stall_flush();
    test_reset_mid_stall();
    test_operand_select();
    test_jump_targets();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
